fifo_wr_arbiter: RTL and testbench

// - Shares the single write port of the cyclic FIFO between NREQ producers.
// - Grants are round-robin and burst-locked: a granted producer writes up to BURST_LEN words before the port is re-arbitrated.
// - Write requests are held off while fifo_full is high, so FIFO overflow cannot occur.
// - Sits between the producer blocks and the FIFO write_data/write_req/fifo_full/fifo_of pins.

---
 rtl/fifo_arb_pkg.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 47 ++++
 rtl/fifo_wr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types, state constants and a width helper for the
//            FIFO write-port arbiter.
// Contents : arb_state_t  - 1-bit arbiter state type (IDLE / BURST)
//            IDLE, BURST  - localparam state encodings used by the FSM
//            clog2()      - ceil(log2(n)), never less than 1
// Optional : none (FIFO_ARB_STATS_EN is consumed by fifo_wr_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // Minimum result of 1 keeps single-entry selectors at a legal width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request at or above rr_ptr, wrapping modulo NREQ.
// Ports    : req     in  NREQ  request vector
//            rr_ptr  in  IW    highest-priority index this round
//            any_req out 1     at least one request set
//            pick_id out IW    selected index (0 when any_req=0)
// Optional : none
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any_req,
  output logic [IW-1:0]   pick_id
);

  // Requests rotated so that bit 0 is the producer at rr_ptr.
  logic [NREQ-1:0] w_rot;

  assign any_req = |req;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rot[i] = req[(int'(rr_ptr) + i) % NREQ];
    end
  end

  // Priority-encode the lowest rotated bit, then map the offset back to a
  // real producer index. Scanning downward lets the lowest offset win.
  always_comb begin
    pick_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        pick_id = IW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Shares the single FIFO write port between NREQ producers with
//            burst-locked round-robin grants. Writes are held off while the
//            FIFO reports full, so the FIFO cannot overflow.
// Ports    : clk         in  1           rising-edge clock
//            rst         in  1           asynchronous reset, active-low
//            req_valid   in  NREQ        producer i presents a word
//            req_data    in  NREQ*DATA   producer words, packed
//            req_ready   out NREQ        one-hot word-accept strobe
//            write_data  out DATA        FIFO write data
//            write_req   out 1           FIFO write request
//            fifo_full   in  1           FIFO full flag
//            fifo_of     in  1           FIFO overflow flag
//            gnt_id      out clog2(NREQ) locked producer (valid while busy)
//            busy        out 1           a grant is locked
//            of_err      out 1           sticky overflow-seen flag
//            stat_words  out NREQ*CNT_W  per-producer word counters (opt.)
//            stat_stall  out CNT_W       stalled-burst cycle counter (opt.)
// Optional : define FIFO_ARB_STATS_EN to add stat_words / stat_stall.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA      = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA-1:0]          write_data,
  output logic                     write_req,
  input  logic                     fifo_full,
  input  logic                     fifo_of,
  output logic [clog2(NREQ)-1:0]   gnt_id,
  output logic                     busy,
  output logic                     of_err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]    stat_words,
  output logic [CNT_W-1:0]         stat_stall
`endif
);

  localparam int IW = clog2(NREQ);
  localparam int BW = clog2(BURST_LEN);

  localparam logic [IW-1:0] c_last_id   = IW'(NREQ - 1);
  localparam logic [BW-1:0] c_last_beat = BW'(BURST_LEN - 1);

  if ((NREQ < 2) || (NREQ > 16)) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ must be in 2..16");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("fifo_wr_arbiter: BURST_LEN must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fifo_wr_arbiter: CNT_W must be at least 1");
  end

  logic [0:0]    r_state;
  logic [IW-1:0] r_gnt;
  logic [IW-1:0] r_rr_ptr;
  logic [BW-1:0] r_beat;
  logic          r_of_err;

  logic          w_busy;
  logic          w_gnt_valid;
  logic          w_accept;
  logic          w_exit;
  logic          w_any_req;
  logic [IW-1:0] w_pick_id;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (r_rr_ptr),
    .any_req (w_any_req),
    .pick_id (w_pick_id)
  );

  assign w_busy      = (r_state == BURST);
  assign w_gnt_valid = req_valid[r_gnt];

  // Zero-latency write path: the locked producer's word goes straight to the
  // FIFO in the same cycle it is presented, unless the FIFO is full.
  assign w_accept = w_busy & w_gnt_valid & ~fifo_full;

  // A full FIFO freezes the burst entirely, including a producer that has
  // dropped valid; the grant is only released once the FIFO can take data.
  assign w_exit = w_busy & ((w_accept & (r_beat == c_last_beat)) |
                            (~w_gnt_valid & ~fifo_full));

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_full) begin
      req_ready[r_gnt] = 1'b1;
    end
  end

  assign write_req  = w_accept;
  assign write_data = req_data[r_gnt*DATA +: DATA];
  assign gnt_id     = r_gnt;
  assign busy       = w_busy;
  assign of_err     = r_of_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick_id;
            r_beat  <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_exit) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_rr_ptr <= (r_gnt == c_last_id) ? '0 : r_gnt + IW'(1);
          end else if (w_accept) begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_of_err <= 1'b0;
    end else begin
      r_of_err <= r_of_err | fifo_of;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat_words
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_accept && (r_gnt == IW'(g))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign stat_words[g*CNT_W +: CNT_W] = r_cnt;
  end

  logic [CNT_W-1:0] r_stat_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_stall <= '0;
    end else if (w_busy && fifo_full && w_gnt_valid) begin
      r_stat_stall <= r_stat_stall + CNT_W'(1);
    end
  end
  assign stat_stall = r_stat_stall;
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter: a cycle-level model of
//            the arbitration rules is compared with the DUT on every cycle,
//            plus directed scenarios with hand-computed expectations.
// Optional : FIFO_ARB_STATS_EN also checks the statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int DATA      = 8;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA-1:0]   req_data;
  logic [NREQ-1:0]        req_ready;
  logic [DATA-1:0]        write_data;
  logic                   write_req;
  logic                   fifo_full;
  logic                   fifo_of;
  logic [1:0]             gnt_id;
  logic                   busy;
  logic                   of_err;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0]  stat_words;
  logic [CNT_W-1:0]       stat_stall;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA      (DATA),
    .NREQ      (NREQ),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .write_data (write_data),
    .write_req  (write_req),
    .fifo_full  (fifo_full),
    .fifo_of    (fifo_of),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .of_err     (of_err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arbitration rules) -------------------
  bit m_busy;
  int m_gnt, m_words, m_ptr;
  bit m_oferr;
  bit chk_en = 1'b0;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_gnt   = 0;
    m_words = 0;
    m_ptr   = 0;
    m_oferr = 1'b0;
  endtask

  // ---------------- observation logs ---------------------------------------
  int          cyc;
  logic [7:0]  log_data[$];
  int          log_gnt[$];
  int          log_cyc[$];
  bit          cyc_busy[64];
  int          cyc_gnt[64];
  bit          cyc_wr[64];
  logic [3:0]  cyc_rdy[64];
  logic [NREQ-1:0] last_acc;

  task automatic clear_logs();
    cyc = 0;
    log_data.delete();
    log_gnt.delete();
    log_cyc.delete();
  endtask

  // Compare process: inputs are stable at the falling edge, so the model's
  // expected outputs for this cycle are checked here and then advanced.
  always @(negedge clk) begin
    logic            exp_wr;
    logic [NREQ-1:0] exp_rdy;
    int              idx;
    if (rst === 1'b1 && chk_en) begin
      exp_wr  = m_busy && req_valid[m_gnt] && !fifo_full;
      exp_rdy = '0;
      if (m_busy && !fifo_full) exp_rdy[m_gnt] = 1'b1;
      chk("busy", busy, m_busy);
      chk("write_req", write_req, exp_wr);
      chk("req_ready", req_ready, exp_rdy);
      chk("of_err", of_err, m_oferr);
      if (m_busy) chk("gnt_id", gnt_id, m_gnt);
      if (exp_wr) chk("write_data", write_data, req_data[m_gnt*DATA +: DATA]);
      // advance model to the state after the coming rising edge
      if (!m_busy) begin
        if (req_valid != '0) begin
          for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) m_gnt = idx;
          end
          m_busy  = 1'b1;
          m_words = 0;
        end
      end else if (!fifo_full) begin
        if (req_valid[m_gnt]) m_words++;
        if (!req_valid[m_gnt] || m_words == BURST_LEN) begin
          m_busy = 1'b0;
          m_ptr  = (m_gnt + 1) % NREQ;
        end
      end
      m_oferr = m_oferr | fifo_of;
    end
    if (rst === 1'b1) begin
      last_acc = req_valid & req_ready;
      if (cyc < 64) begin
        cyc_busy[cyc] = busy;
        cyc_gnt[cyc]  = int'(gnt_id);
        cyc_wr[cyc]   = write_req;
        cyc_rdy[cyc]  = req_ready;
      end
      if (write_req === 1'b1) begin
        log_data.push_back(write_data);
        log_gnt.push_back(int'(gnt_id));
        log_cyc.push_back(cyc);
      end
      cyc++;
    end else begin
      last_acc = '0;
    end
  end

  // ---------------- producers ---------------------------------------------
  int         p_left[NREQ];
  logic [7:0] p_next[NREQ];

  task automatic start_prod(input int i, input int n, input logic [7:0] first);
    p_left[i] = n;
    p_next[i] = first;
    req_data[i*DATA +: DATA] = first;
    req_valid[i] = (n > 0);
  endtask

  task automatic stop_all();
    for (int i = 0; i < NREQ; i++) p_left[i] = 0;
    req_valid = '0;
  endtask

  // One clock: move to just after the rising edge and let every producer
  // whose word was taken present its next one (or go idle).
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_acc[i] && p_left[i] > 0) begin
        p_left[i]--;
        p_next[i] = p_next[i] + 8'd1;
        req_data[i*DATA +: DATA] = p_next[i];
        if (p_left[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    stop_all();
    fifo_full = 1'b0;
    fifo_of   = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_write_req", write_req, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_of_err", of_err, 1'b0);
    chk("rst_gnt_id", gnt_id, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_busy(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_busy", busy, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[10];
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    fifo_of   = 1'b0;
    last_acc  = '0;
    do_reset();
    chk_en = 1'b1;

    // ---- 1: all four producers continuously valid --------------------------
    for (int i = 0; i < NREQ; i++) start_prod(i, 1000, 8'(i * 16));
    repeat (20) tick();
    chk("t1_nwrites", log_data.size(), 16);
    for (int k = 0; k < 16 && k < log_data.size(); k++) begin
      chk("t1_gnt", log_gnt[k], k / 4);
      chk("t1_data", log_data[k], (k / 4) * 16 + (k % 4));
      chk("t1_cycle", log_cyc[k], (k / 4) * 5 + (k % 4) + 1);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("t1_stat_words", stat_words[i*CNT_W +: CNT_W], 4);
    chk("t1_stat_stall", stat_stall, 0);
`endif
    stop_all();
    repeat (2) tick();

    // ---- 2: only producer 2, ten words 0xA0..0xA9 --------------------------
    do_reset();
    start_prod(2, 10, 8'hA0);
    repeat (16) tick();
    exp_c = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
    chk("t2_nwrites", log_data.size(), 10);
    for (int k = 0; k < 10 && k < log_data.size(); k++) begin
      chk("t2_data", log_data[k], 8'hA0 + k);
      chk("t2_gnt", log_gnt[k], 2);
      chk("t2_cycle", log_cyc[k], exp_c[k]);
    end
    // pointer now sits at 3, so producer 3 beats producer 0
    start_prod(0, 1, 8'h00);
    start_prod(3, 1, 8'h30);
    wait_busy(5);
    chk("t2_next_gnt", gnt_id, 2'd3);
    repeat (6) tick();
    stop_all();
    tick();

    // ---- 3: producer 1 stalled by fifo_full after its 2nd word -------------
    do_reset();
    start_prod(1, 4, 8'h10);
    repeat (3) tick();
    fifo_full = 1'b1;
    repeat (5) tick();
    fifo_full = 1'b0;
    repeat (4) tick();
    exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 8; exp_c[3] = 9;
    chk("t3_nwrites", log_data.size(), 4);
    for (int k = 0; k < 4 && k < log_data.size(); k++) begin
      chk("t3_data", log_data[k], 8'h10 + k);
      chk("t3_gnt", log_gnt[k], 1);
      chk("t3_cycle", log_cyc[k], exp_c[k]);
    end
    for (int c = 3; c <= 7; c++) begin
      chk("t3_stall_busy", cyc_busy[c], 1'b1);
      chk("t3_stall_wr", cyc_wr[c], 1'b0);
      chk("t3_stall_rdy", cyc_rdy[c], 4'b0);
      chk("t3_stall_gnt", cyc_gnt[c], 1);
    end
    chk("t3_of_err", of_err, 1'b0);
    stop_all();
    tick();

    // ---- 4: producer 0 drops after one word, producer 3 waiting ------------
    do_reset();
    start_prod(0, 1, 8'h00);
    start_prod(3, 5, 8'h30);
    repeat (8) tick();
    chk("t4_busy0", cyc_busy[0], 1'b0);
    chk("t4_busy1", cyc_busy[1], 1'b1);
    chk("t4_busy2", cyc_busy[2], 1'b1);
    chk("t4_busy3", cyc_busy[3], 1'b0);
    chk("t4_busy4", cyc_busy[4], 1'b1);
    chk("t4_wr1", cyc_wr[1], 1'b1);
    chk("t4_gnt1", cyc_gnt[1], 0);
    chk("t4_gnt4", cyc_gnt[4], 3);
    stop_all();
    tick();

    // ---- 5: asynchronous reset in the middle of producer 1's burst ---------
    do_reset();
    for (int i = 0; i < NREQ; i++) start_prod(i, 1000, 8'(i * 16));
    repeat (7) tick();
    chk("t5_pre_gnt", gnt_id, 2'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_rdy", req_ready, 4'b0);
    chk("t5_async_wr", write_req, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_logs();
    wait_busy(5);
    chk("t5_restart_gnt", gnt_id, 2'd0);
    stop_all();
    repeat (2) tick();

    // ---- randomized traffic against the model ------------------------------
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          start_prod(i, int'($urandom_range(1, 10)), 8'($urandom));
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      fifo_of   = ($urandom_range(0, 999) == 0);
      tick();
    end
    stop_all();
    fifo_full = 1'b0;
    fifo_of   = 1'b0;
    repeat (2) tick();

    // ---- 6: one-cycle fifo_of pulse is sticky until reset ------------------
    do_reset();
    fifo_of = 1'b1;
    tick();
    fifo_of = 1'b0;
    tick();
    chk("t6_of_err_set", of_err, 1'b1);
    repeat (5) tick();
    chk("t6_of_err_hold", of_err, 1'b1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
